// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline front end: machine word, fetch FSM states, NOP encoding.
// The helper computes the sequential fetch address (wraps modulo 2^32).
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    localparam word_t NOP_INSTR = 32'h0000_0000;

    function automatic word_t pc_plus4(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid register holding an instruction word captured while IF/ID is stalled.
// Clear takes priority over load.
module fetch_skid
    import cpu_types_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rst,
    input  logic  i_load,
    input  logic  i_clear,
    input  word_t i_word,
    output logic  o_valid,
    output word_t o_word
);

    logic  r_valid;
    word_t r_word;

    // Captured word and its valid flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_word  <= NOP_INSTR;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            r_word  <= NOP_INSTR;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_word  <= i_word;
        end else begin
            r_valid <= r_valid;
            r_word  <= r_word;
        end
    end

    assign o_valid = r_valid;
    assign o_word  = r_word;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, requests imem, applies redirects, feeds IF/ID.
// Define IFETCH_SKID_EN to keep a stalled hit in a skid buffer instead of refetching it.
module fetch_stage
    import cpu_types_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic [31:0] ifinstr,
    output logic [31:0] ifJALjump_addr,
    output logic        ifW
);

    fetch_state_t r_state, w_state_nxt;
    word_t        r_pc, w_pc_nxt;
    word_t        r_pend, w_pend_nxt;
    word_t        w_pc_plus4;
    word_t        w_instr, w_link;
    logic         w_ren, w_ifw;

`ifdef IFETCH_SKID_EN
    logic  w_skid_load, w_skid_clear, w_skid_valid;
    word_t w_skid_word;

    fetch_skid u_skid (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_word  (imemload),
        .o_valid (w_skid_valid),
        .o_word  (w_skid_word)
    );
`endif

    assign w_pc_plus4 = pc_plus4(r_pc);

    // State, PC and pending redirect target
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= FETCH;
            r_pc    <= PC_INIT;
            r_pend  <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // Next-state and IF/ID outputs; halt beats redirect beats hit/stall
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_pend_nxt  = r_pend;
        w_ren       = 1'b0;
        w_ifw       = 1'b0;
        w_instr     = NOP_INSTR;
        w_link      = w_pc_plus4;
`ifdef IFETCH_SKID_EN
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
`endif
        if (halt) begin
            w_state_nxt = HALT;
            w_link      = 32'h0000_0000;
        end else begin
            case (r_state)
                FETCH: begin
                    w_ren = 1'b1;
                    if (redirect) begin
                        // Flush IF/ID even under stall; a miss must first retire the old request
                        w_ifw = 1'b1;
                        if (ihit) begin
                            w_pc_nxt = redirect_addr;
                        end else begin
                            w_pend_nxt  = redirect_addr;
                            w_state_nxt = DRAIN;
                        end
                    end else if (ihit && !stall) begin
                        w_ifw    = 1'b1;
                        w_instr  = imemload;
                        w_pc_nxt = w_pc_plus4;
                    end else if (ihit) begin
`ifdef IFETCH_SKID_EN
                        w_skid_load = 1'b1;
                        w_state_nxt = HOLD;
`else
                        w_ifw = 1'b0;
`endif
                    end else begin
                        w_ifw = 1'b0;
                    end
                end
                DRAIN: begin
                    w_ren = 1'b1;
                    if (ihit) begin
                        w_pc_nxt    = redirect ? redirect_addr : r_pend;
                        w_state_nxt = FETCH;
                    end else if (redirect) begin
                        w_pend_nxt = redirect_addr;
                    end else begin
                        w_pend_nxt = r_pend;
                    end
                end
`ifdef IFETCH_SKID_EN
                HOLD: begin
                    w_instr = w_skid_valid ? w_skid_word : NOP_INSTR;
                    if (redirect) begin
                        w_ifw        = 1'b1;
                        w_instr      = NOP_INSTR;
                        w_pc_nxt     = redirect_addr;
                        w_skid_clear = 1'b1;
                        w_state_nxt  = FETCH;
                    end else if (!stall) begin
                        w_ifw        = 1'b1;
                        w_pc_nxt     = w_pc_plus4;
                        w_skid_clear = 1'b1;
                        w_state_nxt  = FETCH;
                    end else begin
                        w_ifw = 1'b0;
                    end
                end
`endif
                HALT: begin
                    w_link = 32'h0000_0000;
                end
                default: begin
                    w_state_nxt = FETCH;
                end
            endcase
        end
    end

    assign imemREN        = w_ren & ~RST;
    assign imemaddr       = r_pc;
    assign ifW            = w_ifw & ~RST;
    assign ifinstr        = RST ? NOP_INSTR : w_instr;
    assign ifJALjump_addr = RST ? 32'h0000_0000 : w_link;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; imem returns 0xC0000000 | address.
module tb_fetch_stage;

    logic        CLK;
    logic        RST;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        halt;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic [31:0] ifinstr;
    logic [31:0] ifJALjump_addr;
    logic        ifW;

    int n_pass;
    int n_total;

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_addr  (redirect_addr),
        .halt           (halt),
        .ihit           (ihit),
        .imemload       (imemload),
        .imemREN        (imemREN),
        .imemaddr       (imemaddr),
        .ifinstr        (ifinstr),
        .ifJALjump_addr (ifJALjump_addr),
        .ifW            (ifW)
    );

    assign imemload = 32'hC000_0000 | imemaddr;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Apply one cycle of inputs just after the falling edge; outputs settle before the next rise
    task automatic cyc(input logic s, input logic r, input logic [31:0] ra,
                       input logic h, input logic hit);
        @(negedge CLK);
        stall         = s;
        redirect      = r;
        redirect_addr = ra;
        halt          = h;
        ihit          = hit;
        #1;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        ihit = 1'b1;
        #1;
        n_total++; if (imemREN !== 1'b0) $display("FAIL rst_ren got %b exp 0", imemREN); else n_pass++;
        n_total++; if (ifW !== 1'b0) $display("FAIL rst_ifw got %b exp 0", ifW); else n_pass++;
        n_total++; if (ifinstr !== 32'h0) $display("FAIL rst_instr got %h exp 0", ifinstr); else n_pass++;
        n_total++; if (ifJALjump_addr !== 32'h0) $display("FAIL rst_link got %h exp 0", ifJALjump_addr); else n_pass++;
        n_total++; if (imemaddr !== 32'h0) $display("FAIL rst_addr got %h exp 0", imemaddr); else n_pass++;
        ihit = 1'b0;
        RST  = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            n_total++; if (imemaddr !== 32'(4 * i)) $display("FAIL seq_addr%0d got %h exp %h", i, imemaddr, 32'(4 * i)); else n_pass++;
            n_total++; if (ifW !== 1'b1) $display("FAIL seq_ifw%0d got %b exp 1", i, ifW); else n_pass++;
            n_total++; if (ifJALjump_addr !== 32'(4 * i + 4)) $display("FAIL seq_link%0d got %h exp %h", i, ifJALjump_addr, 32'(4 * i + 4)); else n_pass++;
            n_total++; if (ifinstr !== (32'hC000_0000 | 32'(4 * i))) $display("FAIL seq_instr%0d got %h exp %h", i, ifinstr, 32'hC000_0000 | 32'(4 * i)); else n_pass++;
        end
    endtask

    task automatic test_stall();
        logic exp_ren;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        n_total++; if (imemaddr !== 32'h10) $display("FAIL stall_addr0 got %h exp 00000010", imemaddr); else n_pass++;
        n_total++; if (ifW !== 1'b0) $display("FAIL stall_ifw0 got %b exp 0", ifW); else n_pass++;
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
`ifdef IFETCH_SKID_EN
        exp_ren = 1'b0;
`else
        exp_ren = 1'b1;
`endif
        n_total++; if (imemaddr !== 32'h10) $display("FAIL stall_addr1 got %h exp 00000010", imemaddr); else n_pass++;
        n_total++; if (ifW !== 1'b0) $display("FAIL stall_ifw1 got %b exp 0", ifW); else n_pass++;
        n_total++; if (imemREN !== exp_ren) $display("FAIL stall_ren got %b exp %b", imemREN, exp_ren); else n_pass++;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_total++; if (ifW !== 1'b1) $display("FAIL unstall_ifw got %b exp 1", ifW); else n_pass++;
        n_total++; if (ifinstr !== 32'hC000_0010) $display("FAIL unstall_instr got %h exp c0000010", ifinstr); else n_pass++;
        n_total++; if (ifJALjump_addr !== 32'h14) $display("FAIL unstall_link got %h exp 00000014", ifJALjump_addr); else n_pass++;
    endtask

    task automatic test_redirect_miss();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
        n_total++; if (imemaddr !== 32'h20) $display("FAIL rdm_addr got %h exp 00000020", imemaddr); else n_pass++;
        n_total++; if (ifW !== 1'b1) $display("FAIL rdm_ifw got %b exp 1", ifW); else n_pass++;
        n_total++; if (ifinstr !== 32'h0) $display("FAIL rdm_nop got %h exp 0", ifinstr); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 32'h0, 1'b0, (i == 2) ? 1'b1 : 1'b0);
            n_total++; if (imemaddr !== 32'h20) $display("FAIL drain_addr%0d got %h exp 00000020", i, imemaddr); else n_pass++;
            n_total++; if (ifW !== 1'b0) $display("FAIL drain_ifw%0d got %b exp 0", i, ifW); else n_pass++;
            n_total++; if (imemREN !== 1'b1) $display("FAIL drain_ren%0d got %b exp 1", i, imemREN); else n_pass++;
        end
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_total++; if (imemaddr !== 32'h100) $display("FAIL rdm_target got %h exp 00000100", imemaddr); else n_pass++;
        n_total++; if (ifinstr !== 32'hC000_0100) $display("FAIL rdm_instr got %h exp c0000100", ifinstr); else n_pass++;
    endtask

    task automatic test_double_redirect();
        cyc(1'b0, 1'b1, 32'h300, 1'b0, 1'b0);
        n_total++; if (ifW !== 1'b1) $display("FAIL dbl_ifw got %b exp 1", ifW); else n_pass++;
        cyc(1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
        n_total++; if (imemaddr !== 32'h104) $display("FAIL dbl_addr got %h exp 00000104", imemaddr); else n_pass++;
        n_total++; if (ifW !== 1'b0) $display("FAIL dbl_ifw2 got %b exp 0", ifW); else n_pass++;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_total++; if (ifW !== 1'b0) $display("FAIL dbl_drop got %b exp 0", ifW); else n_pass++;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_total++; if (imemaddr !== 32'h200) $display("FAIL dbl_target got %h exp 00000200", imemaddr); else n_pass++;
        n_total++; if (ifinstr !== 32'hC000_0200) $display("FAIL dbl_instr got %h exp c0000200", ifinstr); else n_pass++;
    endtask

    task automatic test_redirect_stall();
        cyc(1'b1, 1'b1, 32'h80, 1'b0, 1'b1);
        n_total++; if (ifW !== 1'b1) $display("FAIL rs_ifw got %b exp 1", ifW); else n_pass++;
        n_total++; if (ifinstr !== 32'h0) $display("FAIL rs_nop got %h exp 0", ifinstr); else n_pass++;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        n_total++; if (imemaddr !== 32'h80) $display("FAIL rs_target got %h exp 00000080", imemaddr); else n_pass++;
    endtask

    task automatic test_wrap();
        cyc(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_total++; if (ifJALjump_addr !== 32'h0) $display("FAIL wrap_link got %h exp 0", ifJALjump_addr); else n_pass++;
        n_total++; if (ifinstr !== 32'hFFFF_FFFC) $display("FAIL wrap_instr got %h exp fffffffc", ifinstr); else n_pass++;
        cyc(1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
        n_total++; if (imemaddr !== 32'h0) $display("FAIL wrap_addr got %h exp 0", imemaddr); else n_pass++;
    endtask

    task automatic test_halt_reset();
        cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        n_total++; if (imemaddr !== 32'h40) $display("FAIL halt_addr got %h exp 00000040", imemaddr); else n_pass++;
        n_total++; if (imemREN !== 1'b0) $display("FAIL halt_ren got %b exp 0", imemREN); else n_pass++;
        n_total++; if (ifW !== 1'b0) $display("FAIL halt_ifw got %b exp 0", ifW); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, (i == 1) ? 1'b1 : 1'b0, 32'h500, 1'b0, 1'b1);
            n_total++; if (imemREN !== 1'b0) $display("FAIL halted_ren%0d got %b exp 0", i, imemREN); else n_pass++;
            n_total++; if (ifW !== 1'b0) $display("FAIL halted_ifw%0d got %b exp 0", i, ifW); else n_pass++;
            n_total++; if (ifinstr !== 32'h0) $display("FAIL halted_instr%0d got %h exp 0", i, ifinstr); else n_pass++;
        end
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        n_total++; if (imemaddr !== 32'h0) $display("FAIL mrst_addr got %h exp 0", imemaddr); else n_pass++;
        n_total++; if (imemREN !== 1'b0) $display("FAIL mrst_ren got %b exp 0", imemREN); else n_pass++;
        ihit = 1'b0;
        RST  = 1'b0;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_total++; if (imemaddr !== 32'h0) $display("FAIL resume_addr0 got %h exp 0", imemaddr); else n_pass++;
        n_total++; if (ifW !== 1'b1) $display("FAIL resume_ifw got %b exp 1", ifW); else n_pass++;
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        n_total++; if (imemaddr !== 32'h4) $display("FAIL resume_addr1 got %h exp 00000004", imemaddr); else n_pass++;
    endtask

    initial begin
        n_pass        = 0;
        n_total       = 0;
        RST           = 1'b1;
        stall         = 1'b0;
        redirect      = 1'b0;
        redirect_addr = 32'h0;
        halt          = 1'b0;
        ihit          = 1'b0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_miss();
        test_double_redirect();
        test_redirect_stall();
        test_wrap();
        test_halt_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
